// File: rtl/usb_pkg.sv
// usb_pkg: sizing constants and small helpers shared by the USB receive
// path (rcv_usb, rx_data_buffer) and the transmit buffer.
//   USB_DEPTH  : byte capacity of a packet data buffer
//   USB_PTR_W  : width of read/write pointers (wrap at USB_DEPTH)
//   USB_OCC_W  : width of the occupancy counter (holds 0..USB_DEPTH)
package usb_pkg;

   localparam int unsigned USB_DEPTH = 64;
   localparam int unsigned USB_PTR_W = 6;
   localparam int unsigned USB_OCC_W = 7;

   // Accepted operation in a cycle, encoded as {write, read}
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_RDWR = 2'b11
   } buf_op_e;

   // Pointer advance; natural modulo-2^USB_PTR_W wrap gives 63 -> 0
   function automatic logic [USB_PTR_W-1:0] ptr_next(input logic [USB_PTR_W-1:0] p);
      return p + 1'b1;
   endfunction

endpackage

// File: rtl/rx_buffer_mem.sv
// rx_buffer_mem: byte storage for the RX data buffer.
// Register array with one synchronous write port and one asynchronous read
// port. Contents are not reset.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data byte
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module rx_buffer_mem #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_data_buffer.sv
// rx_data_buffer: show-ahead byte FIFO between the USB receiver and the
// bus-side reader.
//   clk                  : system clock
//   n_rst                : asynchronous active-low reset
//   flush                : discard all buffered bytes (highest priority)
//   store_rx_packet_data : write strobe from USB RX
//   rx_packet_data       : byte written on store
//   get_rx_data          : read strobe from bus side
//   rx_data              : byte at head of buffer
//   buffer_occupancy     : number of bytes held (0..DEPTH)
//   full / empty         : registered occupancy flags
//   overflow             : sticky, set when a store is dropped
module rx_data_buffer
   import usb_pkg::*;
#(
   parameter int unsigned DEPTH = USB_DEPTH
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 flush,
   input  logic                 store_rx_packet_data,
   input  logic [7:0]           rx_packet_data,
   input  logic                 get_rx_data,
   output logic [7:0]           rx_data,
   output logic [USB_OCC_W-1:0] buffer_occupancy,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow
);

   logic [USB_PTR_W-1:0] wptr_q, wptr_d;
   logic [USB_PTR_W-1:0] rptr_q, rptr_d;
   logic [USB_OCC_W-1:0] occ_q, occ_d;
   logic                 full_q, full_d;
   logic                 empty_q, empty_d;
   logic                 ovf_q, ovf_d;
   logic                 wr_en, rd_en;
   buf_op_e              op;
   logic [7:0]           mem_rdata;

   always_comb begin
      // A store while full succeeds only if a read frees a slot the same cycle
      wr_en = store_rx_packet_data && (!full_q || get_rx_data) && !flush;
      rd_en = get_rx_data && !empty_q && !flush;
      op    = buf_op_e'({wr_en, rd_en});

      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      ovf_d  = ovf_q | (store_rx_packet_data && full_q && !get_rx_data);

      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         occ_d  = '0;
         ovf_d  = 1'b0;
      end else begin
         if (wr_en) wptr_d = ptr_next(wptr_q);
         if (rd_en) rptr_d = ptr_next(rptr_q);
         case (op)
            OP_WR:   occ_d = occ_q + 1'b1;
            OP_RD:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
         endcase
      end

      full_d  = (occ_d == USB_OCC_W'(DEPTH));
      empty_d = (occ_d == '0);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         occ_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         occ_q   <= occ_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         ovf_q   <= ovf_d;
      end
   end

   // Writes are blocked while reset is held so an in-flight store is aborted
   rx_buffer_mem #(
      .DEPTH (DEPTH),
      .AW    (USB_PTR_W)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (wr_en && n_rst),
      .waddr_i (wptr_q),
      .wdata_i (rx_packet_data),
      .raddr_i (rptr_q),
      .rdata_o (mem_rdata)
   );

   // Memory is never cleared, so the head is forced to zero while empty to
   // present 8'h00 after reset or flush.
   always_comb begin
      rx_data = empty_q ? 8'h00 : mem_rdata;
   end

   assign buffer_occupancy = occ_q;
   assign full             = full_q;
   assign empty            = empty_q;
   assign overflow         = ovf_q;

endmodule

// File: tb/tb_rx_data_buffer.sv
module tb_rx_data_buffer;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       flush = 1'b0;
   logic       store = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic       get = 1'b0;
   logic [7:0] rx_data;
   logic [6:0] occ;
   logic       full, empty, overflow;

   int         n_cmp = 0;
   int         n_fail = 0;
   logic [7:0] sb[$];
   logic       m_ovf = 1'b0;

   always #5 clk = ~clk;

   rx_data_buffer #(.DEPTH(64)) dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .flush                (flush),
      .store_rx_packet_data (store),
      .rx_packet_data       (wdata),
      .get_rx_data          (get),
      .rx_data              (rx_data),
      .buffer_occupancy     (occ),
      .full                 (full),
      .empty                (empty),
      .overflow             (overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_flags();
      check("occupancy", 32'(occ), 32'(sb.size()));
      check("full", 32'(full), 32'(sb.size() == 64));
      check("empty", 32'(empty), 32'(sb.size() == 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (sb.size() > 0) check("head", 32'(rx_data), 32'(sb[0]));
   endtask

   // One clock of stimulus; scoreboard updated from the bench's own model
   task automatic do_op(input bit st, input logic [7:0] d, input bit gt, input bit fl);
      bit wr;
      store = st; wdata = d; get = gt; flush = fl;
      if (fl) begin
         sb.delete();
         m_ovf = 1'b0;
      end else begin
         wr = st && (sb.size() < 64 || gt);
         if (st && sb.size() == 64 && !gt) m_ovf = 1'b1;
         if (gt && sb.size() > 0) begin
            check("read_byte", 32'(rx_data), 32'(sb[0]));
            void'(sb.pop_front());
         end
         if (wr) sb.push_back(d);
      end
      @(posedge clk); #1;
      store = 1'b0; get = 1'b0; flush = 1'b0; wdata = 8'h00;
      check_flags();
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_occ", 32'(occ), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_rx_data", 32'(rx_data), 0);
      n_rst = 1'b1;
      @(posedge clk); #1;

      // Arrival order
      do_op(1, 8'hA5, 0, 0);
      do_op(1, 8'h3C, 0, 0);
      do_op(1, 8'hFF, 0, 0);
      check("order_occ3", 32'(occ), 3);
      repeat (3) do_op(0, 8'h00, 1, 0);
      check("order_empty", 32'(empty), 1);

      // Underflow: gets while empty are ignored
      repeat (5) do_op(0, 8'h00, 1, 0);
      do_op(1, 8'h5A, 0, 0);
      check("underflow_head", 32'(rx_data), 32'h5A);
      do_op(0, 8'h00, 1, 0);

      // Wrap / full / dropped store
      for (int i = 0; i < 64; i++) do_op(1, 8'(i), 0, 0);
      check("full_flag", 32'(full), 1);
      do_op(1, 8'h99, 0, 0);
      check("ovf_set", 32'(overflow), 1);
      check("head_kept", 32'(rx_data), 32'h00);
      for (int i = 0; i < 64; i++) do_op(0, 8'h00, 1, 0);

      // Flush with a same-cycle store at occupancy 20, overflow set
      for (int i = 0; i < 64; i++) do_op(1, 8'(i + 64), 0, 0);
      do_op(1, 8'h99, 0, 0);
      for (int i = 0; i < 44; i++) do_op(0, 8'h00, 1, 0);
      check("pre_flush_occ", 32'(occ), 20);
      check("pre_flush_ovf", 32'(overflow), 1);
      do_op(1, 8'h77, 0, 1);
      check("flush_rx_data", 32'(rx_data), 0);
      do_op(1, 8'h12, 0, 0);
      check("post_flush_head", 32'(rx_data), 32'h12);
      do_op(0, 8'h00, 1, 0);

      // Simultaneous store+get while full, then while empty
      for (int i = 0; i < 64; i++) do_op(1, 8'(i + 128), 0, 0);
      do_op(1, 8'h40, 1, 0);
      check("full_sim_occ", 32'(occ), 64);
      check("full_sim_ovf", 32'(overflow), 0);
      for (int i = 0; i < 63; i++) do_op(0, 8'h00, 1, 0);
      check("last_byte", 32'(rx_data), 32'h40);
      do_op(0, 8'h00, 1, 0);
      do_op(1, 8'h11, 1, 0);
      check("empty_sim_occ", 32'(occ), 1);
      check("empty_sim_head", 32'(rx_data), 32'h11);
      do_op(0, 8'h00, 1, 0);

      // Asynchronous reset mid-stream at occupancy 10
      for (int i = 0; i < 10; i++) do_op(1, 8'(i + 200), 0, 0);
      store = 1'b1; wdata = 8'hEE;
      #2 n_rst = 1'b0;
      #1;
      check("midrst_occ", 32'(occ), 0);
      check("midrst_empty", 32'(empty), 1);
      check("midrst_full", 32'(full), 0);
      check("midrst_ovf", 32'(overflow), 0);
      check("midrst_rx_data", 32'(rx_data), 0);
      store = 1'b0; wdata = 8'h00;
      sb.delete();
      m_ovf = 1'b0;
      @(posedge clk); #4;
      n_rst = 1'b1;
      @(posedge clk); #1;
      check_flags();
      do_op(1, 8'hAB, 0, 0);
      check("resume_head", 32'(rx_data), 32'hAB);
      do_op(0, 8'h00, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
